// File: rtl/shift_pkg.sv
// Shared definitions for the shift datapath front end.
//   WIDTH / SHW : datapath width and shift-amount width
//   FUNCT_*     : MIPS R-type funct codes of the six shift operations
//   bit_rev     : reverses a WIDTH-bit word (maps left shifts onto a right shifter)
package shift_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/right_shift_32.sv
// Logical right barrel shifter, 32 bits.
//   res : a shifted right by sel, zero filled
//   a   : value to shift
//   sel : shift amount 0..31
module right_shift_32 (
    output logic [31:0] res,
    input  logic [31:0] a,
    input  logic [4:0]  sel
);

    assign res = a >> sel;

endmodule

// File: rtl/shift_issue_stage.sv
// Two-stage pipelined front end for the 32-bit shift datapath.
// Decodes MIPS R-type shifts, selects the shift amount, maps left and
// arithmetic shifts onto a logical right shifter and fixes the result up.
//   clk, rst_n              : clock, synchronous active-low reset
//   in_valid / in_ready     : request handshake
//   in_funct, in_shamt      : funct field and instruction shamt
//   in_rs, in_rt            : variable amount source (rs[4:0]) and value to shift
//   in_tag                  : destination register, passed through
//   out_valid / out_ready   : result handshake
//   out_result, out_tag     : shifted value and its tag
//   out_illegal             : funct was not a shift
module shift_issue_stage
    import shift_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [WIDTH-1:0] in_rt,
    input  logic [4:0]       in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_tag,
    output logic             out_illegal
);

    // decode
    logic             dec_left;
    logic             dec_arith;
    logic             dec_var;
    logic             dec_illegal;
    logic [SHW-1:0]   dec_amount;
    logic [WIDTH-1:0] dec_operand;
    logic             rs_hi_unused;

    // stage registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_operand;
    logic [SHW-1:0]   s1_amount;
    logic             s1_left;
    logic             s1_arith;
    logic             s1_illegal;
    logic [4:0]       s1_tag;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic [4:0]       s2_tag;
    logic             s2_illegal;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic [WIDTH-1:0] shr_res;
    logic [WIDTH-1:0] fix_res;

    // only the low bits of rs act as a shift amount
    assign rs_hi_unused = ^in_rs[WIDTH-1:SHW];

    always_comb begin
        dec_left    = 1'b0;
        dec_arith   = 1'b0;
        dec_var     = 1'b0;
        dec_illegal = 1'b0;
        case (in_funct)
            FUNCT_SLL:  dec_left = 1'b1;
            FUNCT_SRL:  ;
            FUNCT_SRA:  dec_arith = 1'b1;
            FUNCT_SLLV: begin dec_left = 1'b1;  dec_var = 1'b1; end
            FUNCT_SRLV: dec_var = 1'b1;
            FUNCT_SRAV: begin dec_arith = 1'b1; dec_var = 1'b1; end
            default:    dec_illegal = 1'b1;
        endcase
    end

    assign dec_amount  = dec_var ? in_rs[SHW-1:0] : in_shamt;
    assign dec_operand = dec_left ? bit_rev(in_rt) : in_rt;

    // flow control; in_ready is combinational from out_ready
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;

    right_shift_32 u_shr (
        .res (shr_res),
        .a   (s1_operand),
        .sel (s1_amount)
    );

    // Sign fill for sra: operand is the unreversed rt there, so bit 31 is the
    // sign. With amount 0 the mask is empty and every op returns rt.
    always_comb begin
        fix_res = s1_left ? bit_rev(shr_res) : shr_res;
        if (s1_arith && s1_operand[WIDTH-1]) begin
            fix_res = fix_res | ~({WIDTH{1'b1}} >> s1_amount);
        end
        if (s1_illegal) begin
            fix_res = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_operand <= '0;
            s1_amount  <= '0;
            s1_left    <= 1'b0;
            s1_arith   <= 1'b0;
            s1_illegal <= 1'b0;
            s1_tag     <= '0;
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_tag     <= '0;
            s2_illegal <= 1'b0;
        end else begin
            // a new accept may overwrite S1 in the same cycle its op moves on
            if (accept) begin
                s1_valid   <= 1'b1;
                s1_operand <= dec_operand;
                s1_amount  <= dec_amount;
                s1_left    <= dec_left;
                s1_arith   <= dec_arith;
                s1_illegal <= dec_illegal;
                s1_tag     <= in_tag;
            end else if (s1_adv) begin
                s1_valid   <= 1'b0;
            end

            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result  <= fix_res;
                    s2_tag     <= s1_tag;
                    s2_illegal <= s1_illegal;
                end
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_result  = s2_result;
    assign out_tag     = s2_tag;
    assign out_illegal = s2_illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_funct;
    logic [4:0]  in_shamt;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    always #5 clk = ~clk;

    shift_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct    (in_funct),
        .in_shamt    (in_shamt),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  tag;
        logic [31:0] exp_res;
        logic        exp_ill;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic last_acc;
    logic use_pending;
    exp_t pending_exp;
    vec_t vecs[20];

    // reference: direct arithmetic on the instruction semantics
    function automatic exp_t model(input logic [5:0] f, input logic [4:0] sh,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [4:0] tag);
        exp_t e;
        logic signed [31:0] srt;
        srt   = rt;
        e.tag = tag;
        e.ill = 1'b0;
        case (f)
            6'h00: e.res = rt << sh;
            6'h02: e.res = rt >> sh;
            6'h03: e.res = srt >>> sh;
            6'h04: e.res = rt << rs[4:0];
            6'h06: e.res = rt >> rs[4:0];
            6'h07: e.res = srt >>> rs[4:0];
            default: begin e.res = 32'h0; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // called right after a negedge with inputs driven; advances one cycle
    task automatic step();
        exp_t e;
        #1;
        last_acc = in_valid && in_ready;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got tag %0d result %h, required no output",
                             out_tag, out_result);
                end else begin
                    e = sb.pop_front();
                    chk("out_result", out_result, e.res);
                    chk("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
                    chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                end
            end
            if (last_acc) begin
                if (use_pending) sb.push_back(pending_exp);
                else sb.push_back(model(in_funct, in_shamt, in_rs, in_rt, in_tag));
            end
        end else begin
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] tag);
        in_funct = f; in_shamt = sh; in_rs = rs; in_rt = rt; in_tag = tag;
        in_valid = 1'b1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] tag);
        int k;
        drive(f, sh, rs, rt, tag);
        k = 0;
        do begin
            step();
            k++;
        end while (!last_acc && k < 50);
        if (!last_acc) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: tag %0d not accepted within 50 cycles", tag);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            step();
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r0;
        logic [4:0]  t0;
        logic [5:0]  fset [8];

        vecs[0]  = '{6'h02, 5'd2,  32'h0,        32'h30004638, 5'd1,  32'h0C00118E, 1'b0};
        vecs[1]  = '{6'h00, 5'd1,  32'h0,        32'h01400052, 5'd2,  32'h028000A4, 1'b0};
        vecs[2]  = '{6'h03, 5'd4,  32'h0,        32'h80000000, 5'd3,  32'hF8000000, 1'b0};
        vecs[3]  = '{6'h03, 5'd4,  32'h0,        32'h40000000, 5'd4,  32'h04000000, 1'b0};
        vecs[4]  = '{6'h06, 5'd9,  32'hFFFFFFE3, 32'h00000040, 5'd5,  32'h00000008, 1'b0};
        vecs[5]  = '{6'h07, 5'd0,  32'd31,       32'h80000001, 5'd6,  32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{6'h00, 5'd0,  32'd3,        32'hDEADBEEF, 5'd8,  32'hDEADBEEF, 1'b0};
        vecs[7]  = '{6'h02, 5'd0,  32'd3,        32'hDEADBEEF, 5'd9,  32'hDEADBEEF, 1'b0};
        vecs[8]  = '{6'h03, 5'd0,  32'd3,        32'hDEADBEEF, 5'd10, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{6'h04, 5'd5,  32'hFFFFFFE0, 32'hDEADBEEF, 5'd11, 32'hDEADBEEF, 1'b0};
        vecs[10] = '{6'h06, 5'd5,  32'hFFFFFFE0, 32'hDEADBEEF, 5'd12, 32'hDEADBEEF, 1'b0};
        vecs[11] = '{6'h07, 5'd5,  32'hFFFFFFE0, 32'hDEADBEEF, 5'd13, 32'hDEADBEEF, 1'b0};
        vecs[12] = '{6'h20, 5'd3,  32'h0,        32'h12345678, 5'd7,  32'h00000000, 1'b1};
        vecs[13] = '{6'h02, 5'd4,  32'h0,        32'h00000100, 5'd14, 32'h00000010, 1'b0};
        vecs[14] = '{6'h04, 5'd0,  32'd4,        32'h0000000F, 5'd15, 32'h000000F0, 1'b0};
        vecs[15] = '{6'h00, 5'd31, 32'h0,        32'h00000003, 5'd16, 32'h80000000, 1'b0};
        vecs[16] = '{6'h02, 5'd31, 32'h0,        32'h80000000, 5'd17, 32'h00000001, 1'b0};
        vecs[17] = '{6'h07, 5'd0,  32'd8,        32'h7F000000, 5'd18, 32'h007F0000, 1'b0};
        vecs[18] = '{6'h01, 5'd2,  32'h0,        32'h0000FFFF, 5'd19, 32'h00000000, 1'b1};
        vecs[19] = '{6'h03, 5'd16, 32'h0,        32'h8000FFFF, 5'd20, 32'hFFFF8000, 1'b0};

        fset[0] = 6'h00; fset[1] = 6'h02; fset[2] = 6'h03; fset[3] = 6'h04;
        fset[4] = 6'h06; fset[5] = 6'h07; fset[6] = 6'h20; fset[7] = 6'h05;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; use_pending = 1'b0;
        in_funct = '0; in_shamt = '0; in_rs = '0; in_rt = '0; in_tag = '0;
        last_acc = 1'b0;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;

        // reset state
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
        chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);

        // table vectors streamed back to back at full rate
        use_pending = 1'b1;
        out_ready   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].funct, vecs[i].shamt, vecs[i].rs, vecs[i].rt, vecs[i].tag);
            pending_exp = '{vecs[i].exp_res, vecs[i].tag, vecs[i].exp_ill};
            step();
            chk("stream_accept", {31'd0, last_acc}, 32'd1);
        end
        drain();

        // latency: accept at edge N, out_valid after edge N+1
        drive(6'h02, 5'd2, 32'h0, 32'h30004638, 5'd21);
        pending_exp = '{32'h0C00118E, 5'd21, 1'b0};
        step();
        chk("lat_accept", {31'd0, last_acc}, 32'd1);
        in_valid = 1'b0;
        #1;
        chk("lat_edge_n", {31'd0, out_valid}, 32'd0);
        step();
        #1;
        chk("lat_edge_n1", {31'd0, out_valid}, 32'd1);
        step();
        drain();

        // backpressure: two ops held, third refused, stable outputs, order kept
        out_ready = 1'b0;
        drive(6'h02, 5'd1, 32'h0, 32'h00000100, 5'd1);
        pending_exp = '{32'h00000080, 5'd1, 1'b0};
        step();
        chk("bp_acc1", {31'd0, last_acc}, 32'd1);
        drive(6'h00, 5'd4, 32'h0, 32'h00000001, 5'd2);
        pending_exp = '{32'h00000010, 5'd2, 1'b0};
        step();
        chk("bp_acc2", {31'd0, last_acc}, 32'd1);
        drive(6'h03, 5'd8, 32'h0, 32'hF0000000, 5'd3);
        pending_exp = '{32'hFFF00000, 5'd3, 1'b0};
        step();
        chk("bp_refuse3", {31'd0, last_acc}, 32'd0);
        r0 = out_result;
        t0 = out_tag;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_stable_result", out_result, r0);
            chk("bp_stable_tag", {27'd0, out_tag}, {27'd0, t0});
            chk("bp_stable_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_acc3_on_release", {31'd0, last_acc}, 32'd1);
        drain();

        // reset with two ops in flight
        out_ready   = 1'b0;
        use_pending = 1'b0;
        issue(6'h02, 5'd1, 32'h0, 32'hAAAA0000, 5'd25);
        issue(6'h00, 5'd1, 32'h0, 32'h0000AAAA, 5'd26);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_result", out_result, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (5) step();
        use_pending = 1'b1;
        pending_exp = '{32'h00000001, 5'd27, 1'b0};
        issue(6'h02, 5'd4, 32'h0, 32'h00000010, 5'd27);
        drain();
        use_pending = 1'b0;

        // randomized traffic against the reference model
        in_valid = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_funct = fset[$urandom_range(0, 7)];
                case ($urandom_range(0, 3))
                    0: in_shamt = 5'd0;
                    1: in_shamt = 5'd31;
                    default: in_shamt = 5'($urandom);
                endcase
                in_rs  = $urandom;
                in_rt  = $urandom;
                in_tag = 5'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
